bus_cycle_decoder: RTL and testbench
====================================

# bus_cycle_decoder

Synchronises the 6809 E/Q bus clocks into the FPGA clock domain, latches address and R/W at each bus cycle, decodes the cycle into SRAM, I/O or ROM regions, and drives registered chip-selects for the memory-side stages. Sits directly upstream of the SRAM controller, which consumes `o_sram_ce` and gates it with the raw E. Also drives 6809 MRDY to stretch accesses to the slow I/O region.

## Interface
- `SRAM_TOP`, 16'hBFFF: last SRAM address; SRAM spans 0x0000..SRAM_TOP.
- `IO_TOP`, 16'hDFFF: last I/O address; I/O spans SRAM_TOP+1..IO_TOP; ROM spans IO_TOP+1..0xFFFF.
- `IO_WAIT`, 4: i_clk cycles MRDY is held low after E rise on I/O cycles. Range 0..15; 0 disables stretching.

Ports:
- `i_clk`, input, 1: system clock. Period ≤ 50 ns.
- `i_rst_n`, input, 1: asynchronous, active-low reset.
- `i_E`, input, 1: 6809 E, asynchronous to i_clk.
- `i_Q`, input, 1: 6809 Q, asynchronous to i_clk.
- `i_RW`, input, 1: 6809 R/W (low = write).
- `i_addr`, input, 16: 6809 address bus.
- `o_sram_ce`, output, 1: SRAM region select (active high).
- `o_io_ce`, output, 1: I/O region select (active high).
- `o_rom_ce`, output, 1: ROM region select (active high).
- `o_rw`, output, 1: R/W latched for the current cycle.
- `o_addr`, output, 16: address latched for the current cycle.
- `o_mrdy`, output, 1: to 6809 MRDY (low = stretch).

## Operation
- i_E and i_Q each pass through a 2-flop synchroniser (reset 0) followed by a previous-value flop. Rise and fall are detected from the last synchroniser stage versus the previous-value flop.
- Registered FSM, 3 states:
  - **IDLE**: all CEs low, o_mrdy high. On Q-rise: latch i_addr into o_addr and i_RW into o_rw, decode, assert exactly one CE, go to DECODED.
  - **DECODED**: on E-rise, go to ACCESS. If the region is I/O and IO_WAIT ≠ 0, load the wait counter with IO_WAIT and drive o_mrdy low on the same edge. On E-fall (missed rise), return to IDLE and clear all CEs.
  - **ACCESS**: while the counter ≠ 0, decrement each clock. o_mrdy is released (high) on the edge where the counter goes 1→0. On E-fall: clear CEs, force o_mrdy high, return to IDLE.
- Decode uses unsigned compares:
  - SRAM when addr ≤ SRAM_TOP.
  - I/O when SRAM_TOP < addr ≤ IO_TOP.
  - Otherwise ROM.
  - Exactly one CE is high outside IDLE.
- Q-rise outside IDLE is ignored. o_addr and o_rw hold their value until the next Q-rise in IDLE.
- Reset (asynchronous, any state): state IDLE; o_sram_ce, o_io_ce, o_rom_ce = 0; o_mrdy = 1; o_rw = 1; o_addr = 0; counter and synchroniser flops = 0.

## Timing
- Let edge S be the first i_clk rise that samples i_Q high. CEs, o_addr and o_rw update on edge S+2. Worst-case delay from pin to output is 3 clock periods, which is ≤ 150 ns at a 50 ns period and lands inside the Q-to-E quarter cycle.
- For E-rise sampled at edge S, o_mrdy goes low at S+2 and returns high at S+2+IO_WAIT.
- For E-fall sampled at edge S, CEs drop at S+2. The SRAM controller's own gating with raw E ends the SRAM strobe first.
- If Q-rise and E-fall are detected in the same clock in ACCESS, E-fall is taken: go to IDLE. The Q-rise is lost and that cycle is not decoded. This cannot occur when the clock period is within spec.
- The wait counter never underflows. If IO_WAIT = 0, o_mrdy stays high.

## Test plan
- Reset mid-ACCESS on an I/O cycle with o_mrdy low: CEs go to 0 and o_mrdy to 1 immediately, without waiting for i_clk. After release, state is IDLE.
- SRAM read at 0x1234, i_RW = 1, at 1 MHz E and 20 MHz clock: o_sram_ce high 2 clocks after Q is sampled and low 2 clocks after E-fall is sampled. o_addr = 0x1234, o_rw = 1, o_mrdy stays 1.
- Boundary decode at 0xBFFF, 0xC000, 0xDFFF and 0xE000: selects are SRAM, I/O, I/O and ROM respectively, with exactly one CE high each time.
- I/O write at 0xC010 with IO_WAIT = 4: o_mrdy is low for exactly 4 clocks, starting 2 clocks after E-rise is sampled. o_rw = 0.
- I/O cycle with IO_WAIT = 0: o_mrdy stays 1 throughout. Separately, a short E pulse that falls while E is held at the synchroniser: FSM returns to IDLE with no CE stuck high.
- Back-to-back cycles SRAM 0x0000 → ROM 0xFFFE → I/O 0xD000: each CE pulses once per cycle, o_addr tracks each address, and no two CEs overlap.

Source files
------------

// File: rtl/bus_cycle_decoder_if.sv
// 6809 bus-side signals seen by the cycle decoder.
// master: the CPU / bench side driving the bus pins.
// slave:  the decoder consuming pins and producing selects and MRDY.
interface bus_cycle_decoder_if;
   logic        i_E;
   logic        i_Q;
   logic        i_RW;
   logic [15:0] i_addr;
   logic        o_sram_ce;
   logic        o_io_ce;
   logic        o_rom_ce;
   logic        o_rw;
   logic [15:0] o_addr;
   logic        o_mrdy;

   modport master (
      output i_E,
      output i_Q,
      output i_RW,
      output i_addr,
      input  o_sram_ce,
      input  o_io_ce,
      input  o_rom_ce,
      input  o_rw,
      input  o_addr,
      input  o_mrdy
   );

   modport slave (
      input  i_E,
      input  i_Q,
      input  i_RW,
      input  i_addr,
      output o_sram_ce,
      output o_io_ce,
      output o_rom_ce,
      output o_rw,
      output o_addr,
      output o_mrdy
   );
endinterface

// File: rtl/bus_cycle_decoder.sv
// 6809 bus cycle decoder.
// Brings E/Q into the i_clk domain, latches address and R/W on Q-rise, decodes the
// access into SRAM / I/O / ROM and drives registered chip-selects. I/O accesses can be
// stretched by holding MRDY low for IO_WAIT clocks after E-rise.
module bus_cycle_decoder #(
   parameter logic [15:0] SRAM_TOP = 16'hBFFF,
   parameter logic [15:0] IO_TOP   = 16'hDFFF,
   parameter int unsigned IO_WAIT  = 4
) (
   input logic                i_clk,
   input logic                i_rst_n,
   bus_cycle_decoder_if.slave bus
);

   localparam logic [3:0] WaitLoad = 4'(IO_WAIT);

   typedef enum logic [1:0] {
      StIdle,
      StDecoded,
      StAccess
   } state_e;

   // Synchroniser stages ([0] first, [1] last) and previous-value flops.
   logic [1:0] e_sync_q;
   logic [1:0] q_sync_q;
   logic       e_prev_q;
   logic       q_prev_q;

   logic e_rise;
   logic e_fall;
   logic q_rise;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        sram_ce_q, sram_ce_d;
   logic        io_ce_q, io_ce_d;
   logic        rom_ce_q, rom_ce_d;
   logic        mrdy_q, mrdy_d;
   logic        rw_q, rw_d;
   logic [15:0] addr_q, addr_d;

   logic hit_sram;
   logic hit_io;
   logic hit_rom;

   // Synchronise E and Q and keep the previous synchronised value for edge detection.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         e_sync_q <= 2'b00;
         q_sync_q <= 2'b00;
         e_prev_q <= 1'b0;
         q_prev_q <= 1'b0;
      end else begin
         e_sync_q <= {e_sync_q[0], bus.i_E};
         q_sync_q <= {q_sync_q[0], bus.i_Q};
         e_prev_q <= e_sync_q[1];
         q_prev_q <= q_sync_q[1];
      end
   end

   assign e_rise = e_sync_q[1] & ~e_prev_q;
   assign e_fall = ~e_sync_q[1] & e_prev_q;
   assign q_rise = q_sync_q[1] & ~q_prev_q;

   // Region decode of the live address; only used at the Q-rise latch point.
   assign hit_sram = (bus.i_addr <= SRAM_TOP);
   assign hit_io   = (bus.i_addr > SRAM_TOP) && (bus.i_addr <= IO_TOP);
   assign hit_rom  = ~hit_sram & ~hit_io;

   // FSM state and all registered outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= StIdle;
         cnt_q     <= 4'd0;
         sram_ce_q <= 1'b0;
         io_ce_q   <= 1'b0;
         rom_ce_q  <= 1'b0;
         mrdy_q    <= 1'b1;
         rw_q      <= 1'b1;
         addr_q    <= 16'h0000;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         sram_ce_q <= sram_ce_d;
         io_ce_q   <= io_ce_d;
         rom_ce_q  <= rom_ce_d;
         mrdy_q    <= mrdy_d;
         rw_q      <= rw_d;
         addr_q    <= addr_d;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      sram_ce_d = sram_ce_q;
      io_ce_d   = io_ce_q;
      rom_ce_d  = rom_ce_q;
      mrdy_d    = mrdy_q;
      rw_d      = rw_q;
      addr_d    = addr_q;

      unique case (state_q)
         StIdle: begin
            sram_ce_d = 1'b0;
            io_ce_d   = 1'b0;
            rom_ce_d  = 1'b0;
            mrdy_d    = 1'b1;
            cnt_d     = 4'd0;
            if (q_rise) begin
               addr_d    = bus.i_addr;
               rw_d      = bus.i_RW;
               sram_ce_d = hit_sram;
               io_ce_d   = hit_io;
               rom_ce_d  = hit_rom;
               state_d   = StDecoded;
            end
         end

         StDecoded: begin
            if (e_fall) begin
               // E was already high at Q-rise; abandon the cycle.
               sram_ce_d = 1'b0;
               io_ce_d   = 1'b0;
               rom_ce_d  = 1'b0;
               mrdy_d    = 1'b1;
               cnt_d     = 4'd0;
               state_d   = StIdle;
            end else if (e_rise) begin
               state_d = StAccess;
               if (io_ce_q && (WaitLoad != 4'd0)) begin
                  cnt_d  = WaitLoad;
                  mrdy_d = 1'b0;
               end
            end
         end

         StAccess: begin
            // E-fall wins over everything, including a coincident Q-rise.
            if (e_fall) begin
               sram_ce_d = 1'b0;
               io_ce_d   = 1'b0;
               rom_ce_d  = 1'b0;
               mrdy_d    = 1'b1;
               cnt_d     = 4'd0;
               state_d   = StIdle;
            end else if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  mrdy_d = 1'b1;
               end
            end
         end

         default: begin
            sram_ce_d = 1'b0;
            io_ce_d   = 1'b0;
            rom_ce_d  = 1'b0;
            mrdy_d    = 1'b1;
            cnt_d     = 4'd0;
            state_d   = StIdle;
         end
      endcase
   end

   assign bus.o_sram_ce = sram_ce_q;
   assign bus.o_io_ce   = io_ce_q;
   assign bus.o_rom_ce  = rom_ce_q;
   assign bus.o_rw      = rw_q;
   assign bus.o_addr    = addr_q;
   assign bus.o_mrdy    = mrdy_q;

   // Exactly one select is active whenever a cycle is in progress.
   a_onehot_ce : assert property (@(posedge i_clk) disable iff (!i_rst_n)
      (state_q != StIdle) |-> $onehot({sram_ce_q, io_ce_q, rom_ce_q}));

endmodule

// File: tb/tb_bus_cycle_decoder.sv
// Directed bench for bus_cycle_decoder: one instance with IO_WAIT=4, one with IO_WAIT=0,
// both driven from the same E/Q/address stimulus at a 20 MHz clock.
`timescale 1ns / 1ps
module tb_bus_cycle_decoder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        e = 1'b0;
   logic        q = 1'b0;
   logic        rw = 1'b1;
   logic [15:0] addr = 16'h0000;

   int checks = 0;
   int errors = 0;

   bus_cycle_decoder_if bus_w ();
   bus_cycle_decoder_if bus_n ();

   assign bus_w.i_E    = e;
   assign bus_w.i_Q    = q;
   assign bus_w.i_RW   = rw;
   assign bus_w.i_addr = addr;
   assign bus_n.i_E    = e;
   assign bus_n.i_Q    = q;
   assign bus_n.i_RW   = rw;
   assign bus_n.i_addr = addr;

   bus_cycle_decoder #(
      .SRAM_TOP (16'hBFFF),
      .IO_TOP   (16'hDFFF),
      .IO_WAIT  (4)
   ) dut_w (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus_w)
   );

   bus_cycle_decoder #(
      .SRAM_TOP (16'hBFFF),
      .IO_TOP   (16'hDFFF),
      .IO_WAIT  (0)
   ) dut_n (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus_n)
   );

   always #25 clk = ~clk;

   logic [2:0] ce_w;
   logic [2:0] ce_n;
   assign ce_w = {bus_w.o_sram_ce, bus_w.o_io_ce, bus_w.o_rom_ce};
   assign ce_n = {bus_n.o_sram_ce, bus_n.o_io_ce, bus_n.o_rom_ce};

   // Background monitors: CE pulse counts, CE overlap, MRDY of the no-wait instance.
   logic [2:0] ce_prev = 3'b000;
   int n_sram = 0;
   int n_io = 0;
   int n_rom = 0;
   int overlap = 0;
   int mrdy_n_low = 0;

   always @(negedge clk) begin
      ce_prev <= ce_w;
      if (ce_w[2] && !ce_prev[2]) n_sram <= n_sram + 1;
      if (ce_w[1] && !ce_prev[1]) n_io <= n_io + 1;
      if (ce_w[0] && !ce_prev[0]) n_rom <= n_rom + 1;
      if ($countones(ce_w) > 1 || $countones(ce_n) > 1) overlap <= overlap + 1;
      if (bus_n.o_mrdy !== 1'b1) mrdy_n_low <= mrdy_n_low + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [15:0] addr;
      logic        rw;
      logic [2:0]  ce;  // {sram, io, rom}
   } vec_t;

   // Full 6809-like cycle: Q-rise, E-rise, Q toggle inside the access, E-fall.
   task automatic bus_cycle(input vec_t v);
      int lows;
      int first_low;
      bit is_io;
      is_io = (v.ce == 3'b010);
      @(negedge clk);
      addr = v.addr;
      rw   = v.rw;
      q    = 1'b1;
      @(posedge clk);          // S
      @(posedge clk); #1;      // S+1
      check("ce_early", ce_w, 3'b000);
      @(posedge clk); #1;      // S+2
      check("ce_decode", ce_w, v.ce);
      check("ce_decode_nowait", ce_n, v.ce);
      check("addr_latch", bus_w.o_addr, v.addr);
      check("rw_latch", bus_w.o_rw, v.rw);
      check("mrdy_before_e", bus_w.o_mrdy, 1'b1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      e = 1'b1;
      lows = 0;
      first_low = -1;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         if (bus_w.o_mrdy !== 1'b1) begin
            lows++;
            if (first_low < 0) first_low = k;
         end
      end
      check("mrdy_low_clocks", lows, is_io ? 4 : 0);
      check("mrdy_low_start", first_low, is_io ? 2 : -1);
      // Q-rise during the access must be ignored and the latches must hold.
      @(negedge clk);
      q    = 1'b0;
      addr = 16'h5A5A;
      rw   = ~v.rw;
      repeat (3) @(negedge clk);
      q = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("addr_hold", bus_w.o_addr, v.addr);
      check("rw_hold", bus_w.o_rw, v.rw);
      check("ce_hold", ce_w, v.ce);
      @(negedge clk);
      q = 1'b0;
      @(negedge clk);
      e = 1'b0;
      @(posedge clk);          // fall sampled
      @(posedge clk); #1;
      check("ce_before_drop", ce_w, v.ce);
      @(posedge clk); #1;
      check("ce_drop", ce_w, 3'b000);
      check("ce_drop_nowait", ce_n, 3'b000);
      check("addr_after_cycle", bus_w.o_addr, v.addr);
      repeat (3) @(posedge clk);
   endtask

   vec_t vecs[6];
   int   s0, i0, r0;

   initial begin
      vecs[0] = '{addr: 16'h1234, rw: 1'b1, ce: 3'b100};
      vecs[1] = '{addr: 16'hBFFF, rw: 1'b1, ce: 3'b100};
      vecs[2] = '{addr: 16'hC000, rw: 1'b1, ce: 3'b010};
      vecs[3] = '{addr: 16'hDFFF, rw: 1'b0, ce: 3'b010};
      vecs[4] = '{addr: 16'hE000, rw: 1'b1, ce: 3'b001};
      vecs[5] = '{addr: 16'hC010, rw: 1'b0, ce: 3'b010};

      // Power-on reset.
      #5 rst_n = 1'b0;
      #5;
      check("rst_ce", ce_w, 3'b000);
      check("rst_mrdy", bus_w.o_mrdy, 1'b1);
      check("rst_rw", bus_w.o_rw, 1'b1);
      check("rst_addr", bus_w.o_addr, 16'h0000);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);

      for (int i = 0; i < 6; i++) begin
         bus_cycle(vecs[i]);
      end

      // Asynchronous reset in the middle of a stretched I/O access.
      @(negedge clk);
      addr = 16'hC010;
      rw   = 1'b1;
      q    = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      e = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("pre_rst_mrdy", bus_w.o_mrdy, 1'b0);
      check("pre_rst_ce", ce_w, 3'b010);
      #5 rst_n = 1'b0;
      #1;
      check("async_rst_ce", ce_w, 3'b000);
      check("async_rst_ce_nowait", ce_n, 3'b000);
      check("async_rst_mrdy", bus_w.o_mrdy, 1'b1);
      check("async_rst_addr", bus_w.o_addr, 16'h0000);
      check("async_rst_rw", bus_w.o_rw, 1'b1);
      @(negedge clk);
      q = 1'b0;
      e = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("post_rst_idle", ce_w, 3'b000);

      // One-clock E pulse on an I/O cycle: enters ACCESS then leaves on the fall.
      @(negedge clk);
      addr = 16'hC000;
      q    = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("pulse_decode", ce_w, 3'b010);
      @(negedge clk);
      e = 1'b1;
      @(negedge clk);
      e = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      check("pulse_mrdy_low", bus_w.o_mrdy, 1'b0);
      check("pulse_ce_access", ce_w, 3'b010);
      @(posedge clk); #1;
      check("pulse_ce_clear", ce_w, 3'b000);
      check("pulse_ce_clear_nowait", ce_n, 3'b000);
      check("pulse_mrdy_release", bus_w.o_mrdy, 1'b1);
      @(negedge clk);
      q = 1'b0;
      repeat (3) @(posedge clk);

      // E already high at Q-rise: rise is missed, E-fall in DECODED returns to IDLE.
      @(negedge clk);
      e = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("idle_ignores_e", ce_w, 3'b000);
      @(negedge clk);
      addr = 16'hE000;
      rw   = 1'b1;
      q    = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("missed_decode", ce_w, 3'b001);
      @(negedge clk);
      e = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      check("missed_hold", ce_w, 3'b001);
      @(posedge clk); #1;
      check("missed_clear", ce_w, 3'b000);
      check("missed_mrdy", bus_w.o_mrdy, 1'b1);
      @(negedge clk);
      q = 1'b0;
      repeat (3) @(posedge clk);

      // Back-to-back SRAM -> ROM -> I/O: one pulse of each select.
      @(negedge clk);
      s0 = n_sram;
      i0 = n_io;
      r0 = n_rom;
      bus_cycle('{addr: 16'h0000, rw: 1'b1, ce: 3'b100});
      bus_cycle('{addr: 16'hFFFE, rw: 1'b1, ce: 3'b001});
      bus_cycle('{addr: 16'hD000, rw: 1'b0, ce: 3'b010});
      @(negedge clk);
      @(negedge clk);
      check("b2b_sram_pulses", n_sram - s0, 1);
      check("b2b_rom_pulses", n_rom - r0, 1);
      check("b2b_io_pulses", n_io - i0, 1);

      check("ce_overlap_count", overlap, 0);
      check("nowait_mrdy_low_count", mrdy_n_low, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule
